// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Grant / owner identifiers.
  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  localparam int DEFAULT_TIMEOUT = 255;

  // Watchdog counter width; TIMEOUT is limited to 1..2^16-1.
  localparam int CNT_W = 16;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the memory slave.
//
// Handshake rules: a request transfers on a cycle where x_req_valid and
// x_req_ready are both high (IFU/LSU -> arbiter) or mem_req_valid and
// mem_req_ready are both high (arbiter -> memory). A requester holds valid
// and payload stable until ready. Responses (x_rsp_valid, mem_rsp_valid)
// are single-cycle pulses with no back-pressure; the receiver must take them.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // IFU side
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_addr;
  logic                  ifu_rsp_valid;
  logic [DATA_W-1:0]     ifu_rdata;
  logic                  ifu_rsp_err;
  // LSU side
  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_addr;
  logic                  lsu_wen;
  logic [DATA_W-1:0]     lsu_wdata;
  logic [DATA_W/8-1:0]   lsu_wmask;
  logic                  lsu_rsp_valid;
  logic [DATA_W-1:0]     lsu_rdata;
  logic                  lsu_rsp_err;
  // Memory side
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rdata;

  // Arbiter view: master of the memory port, responder to IFU/LSU.
  modport master (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  // Environment view: requesters plus the memory slave.
  modport slave (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// Clear/enable cycle counter that flags when TIMEOUT-1 has been reached.
module bus_watchdog
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count while enabled; park at the terminal value so tc can never wrap away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count >= LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between IFU and LSU: round-robin grant on conflict,
// one outstanding transaction, watchdog-terminated hung transactions.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master bus,
  output state_t            dbg_state
);

  localparam int MASK_W = DATA_W / 8;

  state_t              state, state_nxt;
  logic                owner, last_grant, winner;
  logic                accept, rsp_ok, timeout, wd_tc, wd_en;
  logic [DATA_W-1:0]   rsp_data;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [DATA_W-1:0]   ifu_rdata_q, lsu_rdata_q;
  logic                ifu_err_q, lsu_err_q;

  // Grant selection and transaction completion conditions.
  always_comb begin
    if (bus.ifu_req_valid && bus.lsu_req_valid) winner = ~last_grant;
    else if (bus.lsu_req_valid)                 winner = GNT_LSU;
    else                                        winner = GNT_IFU;
    accept  = (state == IDLE) && (bus.ifu_req_valid || bus.lsu_req_valid);
    rsp_ok  = (state == WAIT) && bus.mem_rsp_valid;
    // A handshake in the same cycle as the terminal count takes precedence.
    timeout = wd_tc && (((state == ISSUE) && !bus.mem_req_ready) ||
                        ((state == WAIT)  && !bus.mem_rsp_valid));
    rsp_data = (timeout || wen_q) ? '0 : bus.mem_rdata;
    wd_en    = (state == ISSUE) || (state == WAIT);
  end

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (wd_en),
    .tc  (wd_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: if (bus.mem_req_ready) state_nxt = WAIT;
             else if (timeout)      state_nxt = RESP;
      WAIT:  if (rsp_ok || timeout) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request payload capture, ownership tracking and per-requester response data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= GNT_IFU;
      last_grant  <= GNT_LSU;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      ifu_err_q   <= 1'b0;
      lsu_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= winner;
        last_grant <= winner;
        if (winner == GNT_LSU) begin
          addr_q  <= bus.lsu_addr;
          wen_q   <= bus.lsu_wen;
          wdata_q <= bus.lsu_wdata;
          wmask_q <= bus.lsu_wmask;
        end else begin
          addr_q  <= bus.ifu_addr;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= '0;
        end
      end
      if (rsp_ok || timeout) begin
        if (owner == GNT_LSU) begin
          lsu_rdata_q <= rsp_data;
          lsu_err_q   <= timeout;
        end else begin
          ifu_rdata_q <= rsp_data;
          ifu_err_q   <= timeout;
        end
      end
    end
  end

  // Outputs decoded from state and registered payload.
  always_comb begin
    bus.ifu_req_ready = (state == IDLE) && bus.ifu_req_valid && (winner == GNT_IFU);
    bus.lsu_req_ready = (state == IDLE) && bus.lsu_req_valid && (winner == GNT_LSU);
    bus.ifu_rsp_valid = (state == RESP) && (owner == GNT_IFU);
    bus.lsu_rsp_valid = (state == RESP) && (owner == GNT_LSU);
    bus.ifu_rdata     = ifu_rdata_q;
    bus.ifu_rsp_err   = ifu_err_q;
    bus.lsu_rdata     = lsu_rdata_q;
    bus.lsu_rsp_err   = lsu_err_q;
    bus.mem_req_valid = (state == ISSUE);
    bus.mem_addr      = addr_q;
    bus.mem_wen       = wen_q;
    bus.mem_wdata     = wdata_q;
    bus.mem_wmask     = wmask_q;
    dbg_state         = state;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (TIMEOUT=8).
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  state_t dbg_state;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- memory slave model ----------------
  // auto_mode: zero-wait slave (always ready, response one cycle after accept).
  // otherwise the sequences drive ready/response by hand.
  logic        auto_mode, man_ready, man_rsp, pend;
  logic [31:0] auto_rdata, man_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) pend <= 1'b0;
    else     pend <= auto_mode && bus.mem_req_valid && bus.mem_req_ready;
  end

  assign bus.mem_req_ready = auto_mode ? 1'b1 : man_ready;
  assign bus.mem_rsp_valid = auto_mode ? pend : man_rsp;
  assign bus.mem_rdata     = auto_mode ? auto_rdata : man_rdata;

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ifu_v;
    logic        lsu_v;
    logic [31:0] ifu_addr;
    logic [31:0] lsu_addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] mem_data;
    logic        exp_lsu;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0, 32'h0, 4'h0, 32'h1111_1111,
                1'b0, 32'h0000_1000, 1'b0, 4'h0, 32'h1111_1111};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_1004, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h2222_2222,
                1'b1, 32'h8000_0010, 1'b1, 4'b0011, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h0, 32'h0000_3004, 1'b0, 32'h0, 4'h0, 32'h3333_3333,
                1'b1, 32'h0000_3004, 1'b0, 4'h0, 32'h3333_3333};
    vecs[3] = '{1'b0, 1'b1, 32'h0, 32'h0000_3008, 1'b1, 32'h0123_4567, 4'hF, 32'h4444_4444,
                1'b1, 32'h0000_3008, 1'b1, 4'hF, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_5000, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h5555_5555,
                1'b0, 32'h0000_0040, 1'b0, 4'h0, 32'h5555_5555};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0, 4'h0, 32'h6666_6666,
                1'b0, 32'h0000_0044, 1'b0, 4'h0, 32'h6666_6666};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0048, 32'h0000_6000, 1'b0, 32'h0, 4'h0, 32'h7777_7777,
                1'b1, 32'h0000_6000, 1'b0, 4'h0, 32'h7777_7777};

    // ---------------- defaults and reset ----------------
    bus.ifu_req_valid = 1'b0; bus.ifu_addr = '0;
    bus.lsu_req_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_wen = 1'b0;
    bus.lsu_wdata = '0; bus.lsu_wmask = '0;
    auto_mode = 1'b1; man_ready = 1'b0; man_rsp = 1'b0;
    auto_rdata = '0; man_rdata = '0;

    #2;
    chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 32'd0);
    chk("rst_lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'd0);
    chk("rst_ifu_rsp_err",   32'(bus.ifu_rsp_err), 32'd0);
    chk("rst_lsu_rsp_err",   32'(bus.lsu_rsp_err), 32'd0);
    chk("rst_ifu_rdata",     bus.ifu_rdata, 32'd0);
    chk("rst_lsu_rdata",     bus.lsu_rdata, 32'd0);
    chk("rst_mem_addr",      bus.mem_addr, 32'd0);
    chk("rst_mem_wdata",     bus.mem_wdata, 32'd0);
    chk("rst_mem_wmask",     32'(bus.mem_wmask), 32'd0);
    chk("rst_mem_wen",       32'(bus.mem_wen), 32'd0);
    chk("rst_state",         32'(dbg_state), 32'(IDLE));
    smp();
    rst = 1'b0;
    tick();

    // ---------------- continuous conflict: alternating grants ----------------
    auto_rdata = 32'h5A5A_0001;
    bus.ifu_addr = 32'h0000_0A00;
    bus.lsu_addr = 32'h0000_0B00;
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    for (int t = 0; t < 6; t++) begin
      logic el;
      el = (t % 2) == 1;
      smp();                               // cycle 0: accept
      chk("rr_ifu_ready", 32'(bus.ifu_req_ready), 32'(!el));
      chk("rr_lsu_ready", 32'(bus.lsu_req_ready), 32'(el));
      tick(); smp();                       // cycle 1: issue
      chk("rr_mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("rr_mem_addr", bus.mem_addr, el ? 32'h0000_0B00 : 32'h0000_0A00);
      chk("rr_ready_busy", 32'(bus.ifu_req_ready | bus.lsu_req_ready), 32'd0);
      tick(); smp();                       // cycle 2: wait
      chk("rr_no_rsp_wait", 32'(bus.ifu_rsp_valid | bus.lsu_rsp_valid), 32'd0);
      tick(); smp();                       // cycle 3: response
      chk("rr_ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 32'(!el));
      chk("rr_lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'(el));
      chk("rr_rdata", el ? bus.lsu_rdata : bus.ifu_rdata, 32'h5A5A_0001);
      tick();
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;

    // ---------------- table-driven single transactions ----------------
    for (int i = 0; i < 7; i++) begin
      bus.ifu_req_valid = vecs[i].ifu_v;
      bus.lsu_req_valid = vecs[i].lsu_v;
      bus.ifu_addr  = vecs[i].ifu_addr;
      bus.lsu_addr  = vecs[i].lsu_addr;
      bus.lsu_wen   = vecs[i].wen;
      bus.lsu_wdata = vecs[i].wdata;
      bus.lsu_wmask = vecs[i].wmask;
      auto_rdata    = vecs[i].mem_data;
      smp();
      chk("vec_ifu_ready", 32'(bus.ifu_req_ready), 32'(!vecs[i].exp_lsu));
      chk("vec_lsu_ready", 32'(bus.lsu_req_ready), 32'(vecs[i].exp_lsu));
      tick();
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      smp();
      chk("vec_mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("vec_mem_addr", bus.mem_addr, vecs[i].exp_addr);
      chk("vec_mem_wen", 32'(bus.mem_wen), 32'(vecs[i].exp_wen));
      chk("vec_mem_wmask", 32'(bus.mem_wmask), 32'(vecs[i].exp_wmask));
      if (vecs[i].exp_lsu) chk("vec_mem_wdata", bus.mem_wdata, vecs[i].wdata);
      tick(); smp();
      chk("vec_mem_req_drop", 32'(bus.mem_req_valid), 32'd0);
      chk("vec_no_rsp_wait", 32'(bus.ifu_rsp_valid | bus.lsu_rsp_valid), 32'd0);
      tick(); smp();
      chk("vec_ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 32'(!vecs[i].exp_lsu));
      chk("vec_lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'(vecs[i].exp_lsu));
      chk("vec_rdata", vecs[i].exp_lsu ? bus.lsu_rdata : bus.ifu_rdata, vecs[i].exp_rdata);
      chk("vec_err", 32'(vecs[i].exp_lsu ? bus.lsu_rsp_err : bus.ifu_rsp_err), 32'd0);
      tick();
    end

    // ---------------- timeout in ISSUE (slave never ready) ----------------
    auto_mode = 1'b0; man_ready = 1'b0; man_rsp = 1'b0;
    bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h0000_7000;
    bus.lsu_wen = 1'b0; bus.lsu_wmask = 4'h0;
    smp();
    chk("to_accept", 32'(bus.lsu_req_ready), 32'd1);
    tick();
    bus.lsu_req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      smp();
      chk("to_req_held", 32'(bus.mem_req_valid), 32'd1);
      chk("to_no_rsp_yet", 32'(bus.lsu_rsp_valid), 32'd0);
      tick();
    end
    smp();                                 // cycle 9
    chk("to_rsp_valid", 32'(bus.lsu_rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(bus.lsu_rsp_err), 32'd1);
    chk("to_rdata_zero", bus.lsu_rdata, 32'd0);
    chk("to_req_dropped", 32'(bus.mem_req_valid), 32'd0);
    chk("to_ifu_quiet", 32'(bus.ifu_rsp_valid), 32'd0);
    tick();
    man_rsp = 1'b1; man_rdata = 32'hBAD0_BAD0;   // stale response
    smp();
    chk("stale_no_rsp", 32'(bus.ifu_rsp_valid | bus.lsu_rsp_valid), 32'd0);
    chk("stale_idle", 32'(dbg_state), 32'(IDLE));
    tick();
    man_rsp = 1'b0;
    smp();
    chk("stale_no_rsp2", 32'(bus.ifu_rsp_valid | bus.lsu_rsp_valid), 32'd0);
    chk("stale_rdata_kept", bus.lsu_rdata, 32'd0);
    tick();

    // ---------------- response coincides with terminal count in WAIT ----------------
    bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h0000_8000;
    tick();                                // accepted
    bus.lsu_req_valid = 1'b0;
    man_ready = 1'b1;
    smp();                                 // cycle 1
    chk("co_issue", 32'(bus.mem_req_valid), 32'd1);
    tick();
    man_ready = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      smp();
      chk("co_waiting", 32'(bus.lsu_rsp_valid | bus.mem_req_valid), 32'd0);
      tick();
    end
    man_rsp = 1'b1; man_rdata = 32'hCAFE_F00D;   // cycle 8: count == TIMEOUT-1
    tick();
    man_rsp = 1'b0;
    smp();                                 // cycle 9
    chk("co_rsp_valid", 32'(bus.lsu_rsp_valid), 32'd1);
    chk("co_rsp_err", 32'(bus.lsu_rsp_err), 32'd0);
    chk("co_rdata", bus.lsu_rdata, 32'hCAFE_F00D);
    tick();

    // ---------------- mem_req_ready coincides with terminal count in ISSUE ----------------
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h0000_0100;
    tick();
    bus.ifu_req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      smp();
      chk("ci_issue_held", 32'(bus.mem_req_valid), 32'd1);
      tick();
    end
    man_ready = 1'b1;                      // cycle 8
    tick();
    man_ready = 1'b0;
    man_rsp = 1'b1; man_rdata = 32'h0BAD_F00D;   // cycle 9: now in WAIT
    smp();
    chk("ci_in_wait", 32'(dbg_state), 32'(WAIT));
    chk("ci_no_rsp", 32'(bus.ifu_rsp_valid), 32'd0);
    tick();
    man_rsp = 1'b0;
    smp();
    chk("ci_rsp_valid", 32'(bus.ifu_rsp_valid), 32'd1);
    chk("ci_rsp_err", 32'(bus.ifu_rsp_err), 32'd0);
    chk("ci_rdata", bus.ifu_rdata, 32'h0BAD_F00D);
    tick();

    // ---------------- async reset in WAIT (IFU owner) ----------------
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h0000_0200;
    tick();
    bus.ifu_req_valid = 1'b0;
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    smp();
    chk("ar_in_wait", 32'(dbg_state), 32'(WAIT));
    #2 rst = 1'b1;
    #1;
    chk("ar_state", 32'(dbg_state), 32'(IDLE));
    chk("ar_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("ar_rsp_valid", 32'(bus.ifu_rsp_valid | bus.lsu_rsp_valid), 32'd0);
    chk("ar_ifu_rdata", bus.ifu_rdata, 32'd0);
    chk("ar_mem_addr", bus.mem_addr, 32'd0);
    smp();
    rst = 1'b0;
    tick();
    auto_mode = 1'b1; auto_rdata = 32'h1234_5678;
    bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
    bus.ifu_addr = 32'h0000_0300; bus.lsu_addr = 32'h0000_0400;
    smp();
    chk("ar_conflict_ifu", 32'(bus.ifu_req_ready), 32'd1);
    chk("ar_conflict_lsu", 32'(bus.lsu_req_ready), 32'd0);
    tick();
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    tick(); tick(); smp();
    chk("ar_ifu_rsp", 32'(bus.ifu_rsp_valid), 32'd1);
    chk("ar_ifu_rsp_data", bus.ifu_rdata, 32'h1234_5678);
    tick();

    // ---------------- async reset in ISSUE drops mem_req_valid ----------------
    auto_mode = 1'b0; man_ready = 1'b0;
    bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h0000_0500;
    tick();
    bus.lsu_req_valid = 1'b0;
    smp();
    chk("ai_issue", 32'(bus.mem_req_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("ai_mem_req_drop", 32'(bus.mem_req_valid), 32'd0);
    chk("ai_lsu_rsp", 32'(bus.lsu_rsp_valid), 32'd0);
    smp();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
